// File: rtl/eth_dcp_pkg.sv
// Shared egress decoupled-path definitions: wide payload sizing and field
// positions used by the width-up packer and the downstream buffering FIFO.
package eth_dcp_pkg;

  // Defaults for the standard egress configuration (8-bit beats, 4 lanes).
  localparam int DCP_UP_IN_DW    = 8;
  localparam int DCP_UP_RATIO    = 4;
  localparam int DCP_UP_MASK_LSB = DCP_UP_IN_DW * DCP_UP_RATIO;
  localparam int DCP_UP_LAST_BIT = DCP_UP_MASK_LSB + DCP_UP_RATIO;

  function automatic int dcp_up_pld_w(input int in_dw, input int ratio);
    return in_dw * ratio + ratio + 1;
  endfunction

  function automatic int dcp_up_mask_lsb(input int in_dw, input int ratio);
    return in_dw * ratio;
  endfunction

  function automatic int dcp_up_last_bit(input int in_dw, input int ratio);
    return in_dw * ratio + ratio;
  endfunction

endpackage

// File: rtl/dcp_width_up.sv
// Narrow-to-wide stream packer: gathers RATIO beats (or fewer on an early
// last) into one wide word with a per-lane valid mask and a frame counter.
module dcp_width_up
  import eth_dcp_pkg::*;
#(
  parameter int IN_DW  = 8,
  parameter int RATIO  = 4,
  parameter int OUT_DW = IN_DW * RATIO,
  parameter int CW     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                                   iClk,
  input  logic                                   iRst_n,
  input  logic                                   iDcpIn_Vld,
  output logic                                   iDcpIn_Rdy,
  input  logic [IN_DW:0]                         iDcpIn_Pld,
  output logic                                   oDcpOut_Vld,
  input  logic                                   oDcpOut_Rdy,
  output logic [dcp_up_pld_w(IN_DW, RATIO)-1:0]  oDcpOut_Pld,
  input  logic                                   iFlush,
  output logic [31:0]                            oFrmCnt,
  output logic [CW-1:0]                          oLaneIdx
);

  localparam int LAST_BIT = dcp_up_last_bit(IN_DW, RATIO);

  logic [OUT_DW-1:0] acc_data;
  logic [RATIO-1:0]  acc_mask;
  logic [CW-1:0]     cnt;

  logic              in_last;
  logic [IN_DW-1:0]  in_data;
  logic [OUT_DW-1:0] lane_data;
  logic [RATIO-1:0]  lane_mask;
  logic              accept;
  logic              complete;
  logic              out_fire;

  assign in_last   = iDcpIn_Pld[IN_DW];
  assign in_data   = iDcpIn_Pld[IN_DW-1:0];
  assign lane_data = OUT_DW'(in_data) << (cnt * IN_DW);
  assign lane_mask = RATIO'(1) << cnt;

  // Ready depends only on flush and the output register, so a completing
  // beat can always land in the same edge the old word drains.
  assign iDcpIn_Rdy = ~iFlush & (~oDcpOut_Vld | oDcpOut_Rdy);
  assign accept     = iDcpIn_Vld & iDcpIn_Rdy;
  assign complete   = accept & (in_last | (cnt == CW'(RATIO - 1)));
  assign out_fire   = oDcpOut_Vld & oDcpOut_Rdy;

  assign oLaneIdx = cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      acc_data    <= '0;
      acc_mask    <= '0;
      cnt         <= '0;
      oDcpOut_Vld <= 1'b0;
      oDcpOut_Pld <= '0;
      oFrmCnt     <= '0;
    end else if (iFlush) begin
      acc_data    <= '0;
      acc_mask    <= '0;
      cnt         <= '0;
      oDcpOut_Vld <= 1'b0;
    end else begin
      if (out_fire && oDcpOut_Pld[LAST_BIT])
        oFrmCnt <= oFrmCnt + 32'd1;

      if (complete) begin
        oDcpOut_Vld <= 1'b1;
        oDcpOut_Pld <= {in_last, acc_mask | lane_mask, acc_data | lane_data};
      end else if (oDcpOut_Rdy) begin
        oDcpOut_Vld <= 1'b0;
      end

      if (complete) begin
        acc_data <= '0;
        acc_mask <= '0;
        cnt      <= '0;
      end else if (accept) begin
        acc_data <= acc_data | lane_data;
        acc_mask <= acc_mask | lane_mask;
        cnt      <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcp_width_up.sv
// Scoreboard bench for dcp_width_up at IN_DW=8, RATIO=4.
module tb_dcp_width_up;

  localparam int IN_DW = 8;
  localparam int RATIO = 4;
  localparam int PW    = 37;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [8:0]    in_pld = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [PW-1:0] out_pld;
  logic          fl = 1'b0;
  logic [31:0]   frm;
  logic [1:0]    lane;

  always #5 clk = ~clk;

  dcp_width_up #(.IN_DW(IN_DW), .RATIO(RATIO)) dut (
    .iClk(clk), .iRst_n(rst_n),
    .iDcpIn_Vld(in_vld), .iDcpIn_Rdy(in_rdy), .iDcpIn_Pld(in_pld),
    .oDcpOut_Vld(out_vld), .oDcpOut_Rdy(out_rdy), .oDcpOut_Pld(out_pld),
    .iFlush(fl), .oFrmCnt(frm), .oLaneIdx(lane)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] q[$];
  int          m_lane = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_mask = '0;
  int          m_frm = 0;
  int          stall_left = 0;
  bit          rand_mode = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic next_ordy();
    if (rand_mode) return 1'($urandom_range(0, 1));
    if (stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_lane = 0;
    m_data = '0;
    m_mask = '0;
  endtask

  // One clock cycle: drive after the falling edge, check, advance the model.
  task automatic cycle(input logic vld, input logic [7:0] data, input logic last,
                       input logic ordy, input logic flush, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    in_vld  = vld;
    in_pld  = {last, data};
    out_rdy = ordy;
    fl      = flush;
    #1;
    check_eq("out_vld", 64'(out_vld), 64'(q.size() != 0));
    if (q.size() != 0) check_eq("out_pld", 64'(out_pld), q[0]);
    check_eq("lane_idx", 64'(lane), 64'(m_lane));
    check_eq("frm_cnt", 64'(frm), 64'(m_frm));
    exp_rdy = !flush && (q.size() == 0 || ordy);
    check_eq("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    if (flush) begin
      q.delete();
      model_clear();
    end else if (q.size() != 0 && ordy) begin
      if (q[0][36]) m_frm++;
      void'(q.pop_front());
    end
    acc = vld && exp_rdy;
    if (acc) begin
      m_data = m_data | (32'(data) << (8 * m_lane));
      m_mask = m_mask | (4'(1) << m_lane);
      if (last || m_lane == RATIO - 1) begin
        q.push_back({27'd0, last, m_mask, m_data});
        model_clear();
      end else begin
        m_lane++;
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    logic a;
    int   tries;
    tries = 0;
    do begin
      cycle(1'b1, d, l, next_ordy(), 1'b0, a);
      tries++;
    end while (!a && tries < 200);
    if (!a) check_eq("accept_timeout", 64'(a), 64'd1);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, next_ordy(), 1'b0, a);
  endtask

  task automatic peek_word(input string tag, input logic [PW-1:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, 64'(out_pld), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   nlast;
    int   base;
    logic lst;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_vld", 64'(out_vld), 64'd0);
    check_eq("rst_pld", 64'(out_pld), 64'd0);
    check_eq("rst_frm", 64'(frm), 64'd0);
    check_eq("rst_lane", 64'(lane), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate word
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
    peek_word("full_word", {1'b1, 4'b1111, 32'h44332211});
    idle(2);
    check_eq("frm_after_full", 64'(frm), 64'd1);

    // Short frame followed by a full frame
    send_beat(8'hAA, 0); send_beat(8'hBB, 1);
    peek_word("short_word", {1'b1, 4'b0011, 32'h0000BBAA});
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 1);
    peek_word("after_short", {1'b1, 4'b1111, 32'h04030201});
    idle(2);

    // Back-pressure across an 8-beat stream
    stall_left = 10;
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
    idle(3);
    check_eq("bp_drained", 64'(q.size()), 64'd0);

    // Random streaming
    rand_mode = 1;
    base = m_frm;
    nlast = 0;
    for (int i = 0; i < 400; i++) begin
      while ($urandom_range(0, 3) == 0) idle(1);
      lst = (i == 399) ? 1'b1 : ($urandom_range(0, 4) == 0);
      if (lst) nlast++;
      send_beat(8'($urandom), lst);
    end
    rand_mode = 0;
    idle(3);
    check_eq("frm_random", 64'(frm), 64'(base + nlast));

    // Flush mid-word
    send_beat(8'h11, 0); send_beat(8'h22, 0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, a);
    check_eq("flush_not_accepted", 64'(a), 64'd0);
    idle(1);
    send_beat(8'h33, 1);
    peek_word("flush_word", {1'b1, 4'b0001, 32'h00000033});
    idle(2);

    // Reset mid-stream with a stalled word pending
    stall_left = 100;
    send_beat(8'hC1, 0); send_beat(8'hC2, 0); send_beat(8'hC3, 0); send_beat(8'hC4, 0);
    idle(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", 64'(out_vld), 64'd0);
    check_eq("mid_rst_pld", 64'(out_pld), 64'd0);
    check_eq("mid_rst_frm", 64'(frm), 64'd0);
    q.delete();
    model_clear();
    m_frm = 0;
    stall_left = 0;
    out_rdy = 1'b1;
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    send_beat(8'h5A, 1);
    peek_word("post_rst_word", {1'b1, 4'b0001, 32'h0000005A});
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
